// File: rtl/exc_commit_unit_pkg.sv
// Shared cause codes, FSM encodings and the per-instruction exception record
// for exc_commit_unit.
package exc_commit_unit_pkg;

    localparam int PC_W     = 32;
    localparam int ECODE_W  = 6;
    localparam int ESUB_W   = 9;

    localparam logic [ECODE_W-1:0] ECODE_INT  = 6'h00;
    localparam logic [ECODE_W-1:0] ECODE_ADEF = 6'h08;
    localparam logic [ECODE_W-1:0] ECODE_ALE  = 6'h09;
    localparam logic [ECODE_W-1:0] ECODE_SYS  = 6'h0B;
    localparam logic [ECODE_W-1:0] ECODE_BRK  = 6'h0C;
    localparam logic [ECODE_W-1:0] ECODE_INE  = 6'h0D;
    localparam logic [ESUB_W-1:0]  ESUB_NONE  = 9'h000;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] pc;
        logic            intr;
        logic            adef;
        logic            ine;
        logic            sys;
        logic            brk;
        logic            ertn;
        logic            ale;
    } exc_rec_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority exception cause encoder for the record sitting in MEM.
module exc_prio_enc
    import exc_commit_unit_pkg::*;
(
    input  logic               valid,
    input  logic               intr,
    input  logic               adef,
    input  logic               ine,
    input  logic               sys,
    input  logic               brk,
    input  logic               ale,
    output logic               fault,
    output logic [ECODE_W-1:0] ecode,
    output logic [ESUB_W-1:0]  esubcode
);

    always_comb begin
        fault    = 1'b0;
        ecode    = '0;
        esubcode = ESUB_NONE;
        if (valid) begin
            fault = 1'b1;
            priority case (1'b1)
                intr:    ecode = ECODE_INT;
                adef:    ecode = ECODE_ADEF;
                ine:     ecode = ECODE_INE;
                sys:     ecode = ECODE_SYS;
                brk:     ecode = ECODE_BRK;
                ale:     ecode = ECODE_ALE;
                default: fault = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/exc_commit_unit.sv
// Carries ID/EX exception causes to MEM, commits one trigger or ERTN to the CSR file.
// Optional EXC_ADDR_CHECK_EN: internal PC alignment check and EX_mem_misalign input.
module exc_commit_unit
    import exc_commit_unit_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               ID_valid,
    input  logic [PC_W-1:0]    ID_pc,
    input  logic               ID_adef,
    input  logic               ID_ine,
    input  logic               ID_sys,
    input  logic               ID_brk,
    input  logic               ID_ertn,
    input  logic               EX_ale,
`ifdef EXC_ADDR_CHECK_EN
    input  logic               EX_mem_misalign,
`endif
    input  logic               INT,
    input  logic [PC_W-1:0]    EENTRY_out,
    input  logic [PC_W-1:0]    ERA_out,
    output logic               exc_sig,
    output logic [ECODE_W-1:0] Ecode,
    output logic [ESUB_W-1:0]  EsubCode,
    output logic [PC_W-1:0]    PC,
    output logic               ERTN,
    output logic               flush,
    output logic               redirect_valid,
    output logic [PC_W-1:0]    redirect_pc
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    logic [0:0]         state;
    logic [CNT_W-1:0]   cnt;
    exc_rec_t           rec_ex;
    exc_rec_t           rec_mem;
    exc_rec_t           id_rec;
    exc_rec_t           mem_next;
    logic               idle;
    logic               id_adef;
    logic               ex_ale;
    logic               int_busy;
    logic               int_tag;
    logic               fault;
    logic [ECODE_W-1:0] enc_ecode;
    logic [ESUB_W-1:0]  enc_esub;

`ifdef EXC_ADDR_CHECK_EN
    assign id_adef = ID_adef | (ID_pc[1:0] != 2'b00);
    assign ex_ale  = EX_ale | EX_mem_misalign;
`else
    assign id_adef = ID_adef;
    assign ex_ale  = EX_ale;
`endif

    assign idle = (state == ST_IDLE);

    // Only one interrupt-tagged instruction may be in flight at a time.
    assign int_busy = (rec_ex.valid & rec_ex.intr)
                    | (rec_mem.valid & rec_mem.intr);
    assign int_tag  = INT & ID_valid & idle & ~int_busy;

    always_comb begin
        id_rec       = '0;
        id_rec.valid = ID_valid;
        id_rec.pc    = ID_pc;
        id_rec.intr  = int_tag;
        id_rec.adef  = id_adef;
        id_rec.ine   = ID_ine;
        id_rec.sys   = ID_sys;
        id_rec.brk   = ID_brk;
        id_rec.ertn  = ID_ertn;
        mem_next     = rec_ex;
        mem_next.ale = rec_ex.ale | ex_ale;
    end

    exc_prio_enc u_prio (
        .valid    (rec_mem.valid),
        .intr     (rec_mem.intr),
        .adef     (rec_mem.adef),
        .ine      (rec_mem.ine),
        .sys      (rec_mem.sys),
        .brk      (rec_mem.brk),
        .ale      (rec_mem.ale),
        .fault    (fault),
        .ecode    (enc_ecode),
        .esubcode (enc_esub)
    );

    assign exc_sig = fault & idle;
    assign ERTN    = rec_mem.valid & rec_mem.ertn & ~fault & idle;
    assign flush   = exc_sig | ERTN;

    assign Ecode          = exc_sig ? enc_ecode : '0;
    assign EsubCode       = exc_sig ? enc_esub : '0;
    assign PC             = exc_sig ? rec_mem.pc : '0;
    assign redirect_valid = flush;
    assign redirect_pc    = exc_sig ? EENTRY_out
                          : ERTN    ? ERA_out
                          :           '0;

    // A flush wins over stall so a stalled faulting record cannot retrigger.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rec_ex  <= '0;
            rec_mem <= '0;
        end else if (flush) begin
            rec_ex.valid  <= 1'b0;
            rec_mem.valid <= 1'b0;
        end else if (!stall) begin
            rec_ex  <= id_rec;
            rec_mem <= mem_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (flush) begin
                        state <= ST_FLUSH;
                        cnt   <= CNT_LOAD;
                    end
                end
                ST_FLUSH: begin
                    if (cnt == '0) state <= ST_IDLE;
                    else           cnt   <= cnt - 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exc_commit_unit.sv
// Directed bench for exc_commit_unit with a cycle-level reference model
// compared on every falling clock edge.
module tb_exc_commit_unit;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        ID_valid = 1'b0;
    logic [31:0] ID_pc = '0;
    logic        ID_adef = 1'b0;
    logic        ID_ine = 1'b0;
    logic        ID_sys = 1'b0;
    logic        ID_brk = 1'b0;
    logic        ID_ertn = 1'b0;
    logic        EX_ale = 1'b0;
    logic        INT = 1'b0;
    logic [31:0] EENTRY_out = 32'h1C008000;
    logic [31:0] ERA_out = 32'h1C000204;

    logic        exc_sig;
    logic [5:0]  Ecode;
    logic [8:0]  EsubCode;
    logic [31:0] PC;
    logic        ERTN;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    exc_commit_unit #(.FLUSH_CYCLES(FC), .CNT_W(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .ID_valid       (ID_valid),
        .ID_pc          (ID_pc),
        .ID_adef        (ID_adef),
        .ID_ine         (ID_ine),
        .ID_sys         (ID_sys),
        .ID_brk         (ID_brk),
        .ID_ertn        (ID_ertn),
        .EX_ale         (EX_ale),
        .INT            (INT),
        .EENTRY_out     (EENTRY_out),
        .ERA_out        (ERA_out),
        .exc_sig        (exc_sig),
        .Ecode          (Ecode),
        .EsubCode       (EsubCode),
        .PC             (PC),
        .ERTN           (ERTN),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one slot per pipeline stage plus remaining flush cycles.
    typedef struct {
        bit        v;
        bit [31:0] pc;
        bit        i;
        bit        adef;
        bit        ine;
        bit        sys;
        bit        brk;
        bit        ertn;
        bit        ale;
    } mrec_t;

    mrec_t m_ex = '{default: 0};
    mrec_t m_mem = '{default: 0};
    int    m_left = 0;

    function automatic void prio(input mrec_t r, output bit f, output bit [5:0] c);
        bit       flags [6];
        bit [5:0] codes [6];
        flags = '{r.i, r.adef, r.ine, r.sys, r.brk, r.ale};
        codes = '{6'h00, 6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};
        f = 1'b0;
        c = 6'h00;
        if (r.v) begin
            for (int k = 0; k < 6; k++) begin
                if (flags[k] && !f) begin
                    f = 1'b1;
                    c = codes[k];
                end
            end
        end
    endfunction

    function automatic void model_out(output bit x, output bit r,
                                      output bit [5:0] ec,
                                      output bit [31:0] pc,
                                      output bit [31:0] rp);
        bit       f;
        bit [5:0] c;
        prio(m_mem, f, c);
        x  = f && (m_left == 0);
        r  = m_mem.v && m_mem.ertn && !f && (m_left == 0);
        ec = x ? c : 6'h00;
        pc = x ? m_mem.pc : 32'h0;
        rp = x ? EENTRY_out : (r ? ERA_out : 32'h0);
    endfunction

    bit        u_x, u_r, u_busy, u_idle;
    bit [5:0]  u_ec;
    bit [31:0] u_pc, u_rp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ex   = '{default: 0};
            m_mem  = '{default: 0};
            m_left = 0;
        end else begin
            model_out(u_x, u_r, u_ec, u_pc, u_rp);
            u_idle = (m_left == 0);
            u_busy = (m_ex.v && m_ex.i) || (m_mem.v && m_mem.i);
            if (u_x || u_r) begin
                m_ex.v  = 1'b0;
                m_mem.v = 1'b0;
                m_left  = FC;
            end else begin
                if (m_left > 0) m_left--;
                if (!stall) begin
                    m_mem     = m_ex;
                    m_mem.ale = m_ex.ale | EX_ale;
                    m_ex = '{v: ID_valid, pc: ID_pc,
                             i: INT && ID_valid && u_idle && !u_busy,
                             adef: ID_adef, ine: ID_ine, sys: ID_sys,
                             brk: ID_brk, ertn: ID_ertn, ale: 1'b0};
                end
            end
        end
    end

    bit        c_x, c_r;
    bit [5:0]  c_ec;
    bit [31:0] c_pc, c_rp;

    always @(negedge clk) begin
        model_out(c_x, c_r, c_ec, c_pc, c_rp);
        chk("sb_exc_sig", 32'(exc_sig), 32'(c_x));
        chk("sb_Ecode", 32'(Ecode), 32'(c_ec));
        chk("sb_EsubCode", 32'(EsubCode), 32'h0);
        chk("sb_PC", PC, c_pc);
        chk("sb_ERTN", 32'(ERTN), 32'(c_r));
        chk("sb_flush", 32'(flush), 32'(c_x | c_r));
        chk("sb_redirect_valid", 32'(redirect_valid), 32'(c_x | c_r));
        chk("sb_redirect_pc", redirect_pc, c_rp);
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_id(bit [31:0] pc, bit adef, bit ine, bit sys,
                            bit brk, bit ertn, bit intr);
        ID_valid = 1'b1;
        ID_pc    = pc;
        ID_adef  = adef;
        ID_ine   = ine;
        ID_sys   = sys;
        ID_brk   = brk;
        ID_ertn  = ertn;
        INT      = intr;
    endtask

    task automatic clear_id();
        ID_valid = 1'b0;
        ID_pc    = '0;
        ID_adef  = 1'b0;
        ID_ine   = 1'b0;
        ID_sys   = 1'b0;
        ID_brk   = 1'b0;
        ID_ertn  = 1'b0;
        INT      = 1'b0;
    endtask

    initial begin
        step(2);
        chk("rst_exc_sig", 32'(exc_sig), 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        rst = 1'b0;
        step(1);

        // SYSCALL, then an INT-tagged candidate in the last FLUSH cycle
        drive_id(32'h1C000100, 0, 0, 1, 0, 0, 0);
        step(1);
        clear_id();
        step(1);
        chk("sys_exc_sig", 32'(exc_sig), 32'h1);
        chk("sys_ecode", 32'(Ecode), 32'h0B);
        chk("sys_pc", PC, 32'h1C000100);
        chk("sys_redirect_pc", redirect_pc, 32'h1C008000);
        chk("sys_flush", 32'(flush), 32'h1);
        step(1);
        chk("sys_flush_one_cycle", 32'(flush), 32'h0);
        step(1);
        drive_id(32'h1C000180, 0, 0, 0, 0, 0, 1);
        step(1);
        clear_id();
        step(1);
        chk("flush_window_no_tag", 32'(exc_sig), 32'h0);
        step(1);

        // INE and SYS together
        drive_id(32'h1C000110, 0, 1, 1, 0, 0, 0);
        step(1);
        clear_id();
        step(1);
        chk("ine_sys_exc", 32'(exc_sig), 32'h1);
        chk("ine_sys_ecode", 32'(Ecode), 32'h0D);
        step(4);

        // interrupt tag plus second pulse while in flight
        drive_id(32'h1C000200, 0, 0, 0, 0, 0, 1);
        step(1);
        drive_id(32'h1C000204, 0, 0, 0, 0, 0, 1);
        step(1);
        clear_id();
        chk("int_exc", 32'(exc_sig), 32'h1);
        chk("int_ecode", 32'(Ecode), 32'h00);
        chk("int_pc", PC, 32'h1C000200);
        step(4);

        // ERTN
        drive_id(32'h1C000300, 0, 0, 0, 0, 1, 0);
        step(1);
        clear_id();
        step(1);
        chk("ertn_ertn", 32'(ERTN), 32'h1);
        chk("ertn_exc", 32'(exc_sig), 32'h0);
        chk("ertn_redirect_pc", redirect_pc, 32'h1C000204);
        chk("ertn_flush", 32'(flush), 32'h1);
        step(4);

        // fault beats ertn
        drive_id(32'h1C000310, 0, 0, 0, 1, 1, 0);
        step(1);
        clear_id();
        step(1);
        chk("ertn_brk_exc", 32'(exc_sig), 32'h1);
        chk("ertn_brk_ertn", 32'(ERTN), 32'h0);
        chk("ertn_brk_ecode", 32'(Ecode), 32'h0C);
        step(4);

        // stall holds a BRK in EX for 3 cycles
        drive_id(32'h1C000400, 0, 0, 0, 1, 0, 0);
        step(1);
        clear_id();
        stall = 1'b1;
        step(3);
        chk("stall_held", 32'(exc_sig), 32'h0);
        stall = 1'b0;
        step(1);
        chk("stall_exc", 32'(exc_sig), 32'h1);
        chk("stall_ecode", 32'(Ecode), 32'h0C);
        chk("stall_pc", PC, 32'h1C000400);
        step(4);

        // ALE from EX, then ADEF beating ALE
        drive_id(32'h1C000500, 0, 0, 0, 0, 0, 0);
        step(1);
        clear_id();
        EX_ale = 1'b1;
        step(1);
        EX_ale = 1'b0;
        chk("ale_ecode", 32'(Ecode), 32'h09);
        step(4);
        drive_id(32'h1C000510, 1, 0, 0, 0, 0, 0);
        step(1);
        clear_id();
        EX_ale = 1'b1;
        step(1);
        EX_ale = 1'b0;
        chk("adef_ale_ecode", 32'(Ecode), 32'h08);
        step(4);

        // stall with a fault already in MEM
        drive_id(32'h1C000600, 0, 1, 0, 0, 0, 0);
        step(1);
        clear_id();
        step(1);
        stall = 1'b1;
        chk("stall_mem_exc", 32'(exc_sig), 32'h1);
        step(4);
        chk("stall_mem_cleared", 32'(exc_sig), 32'h0);
        stall = 1'b0;
        step(2);

        // asynchronous reset with an active trigger
        drive_id(32'h1C000700, 0, 0, 1, 0, 0, 0);
        step(1);
        clear_id();
        step(1);
        chk("pre_rst_exc", 32'(exc_sig), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_exc", 32'(exc_sig), 32'h0);
        chk("async_rst_redirect", 32'(redirect_valid), 32'h0);
        step(1);
        rst = 1'b0;
        step(1);

        // reset in the middle of FLUSH, then a fresh fault
        drive_id(32'h1C000710, 0, 0, 1, 0, 0, 0);
        step(1);
        clear_id();
        step(2);
        #2 rst = 1'b1;
        #1;
        chk("mid_flush_rst_flush", 32'(flush), 32'h0);
        chk("mid_flush_rst_pc", PC, 32'h0);
        step(1);
        rst = 1'b0;
        drive_id(32'h1C000800, 0, 0, 0, 1, 0, 0);
        step(1);
        clear_id();
        step(1);
        chk("post_rst_exc", 32'(exc_sig), 32'h1);
        chk("post_rst_ecode", 32'(Ecode), 32'h0C);
        step(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exc_commit_unit.md
Name: exc_commit_unit

Overview:
- Collects exception causes raised in ID and EX and carries them with the instruction into MEM.
- Tags pending interrupts onto the next valid ID instruction.
- In MEM, picks one cause by fixed priority and drives the CSR file's exception-trigger and ERTN inputs.
- Issues pipeline flush and PC redirect (to EENTRY or ERA), then holds a short flush window. Sits between the ID/EX/MEM pipeline registers and the CSR file.

Parameters:
- FLUSH_CYCLES, 2, cycles in FLUSH state after a trigger or ERTN (min 1); no new trigger or interrupt tag while in FLUSH.
- CNT_W, 2, width of the flush counter; must hold FLUSH_CYCLES.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  pipeline stall; record registers hold when 1
- ID_valid  in  1  ID holds a real instruction
- ID_pc  in  32  PC of ID instruction
- ID_adef  in  1  fetch address error reported by IF
- ID_ine  in  1  illegal instruction
- ID_sys  in  1  SYSCALL
- ID_brk  in  1  BREAK
- ID_ertn  in  1  ERTN decoded
- EX_ale  in  1  misaligned load/store address computed in EX
- INT  in  1  interrupt request from the CSR file
- EENTRY_out  in  32  exception entry from the CSR file
- ERA_out  in  32  return address from the CSR file
- exc_sig  out  1  trigger exception (to CSR)
- Ecode  out  6  cause code (to CSR)
- EsubCode  out  9  sub-code (to CSR)
- PC  out  32  PC of the faulting MEM instruction (to CSR)
- ERTN  out  1  return from exception (to CSR)
- flush  out  1  kill IF/ID/EX and the MEM writeback
- redirect_valid  out  1  next-PC override valid
- redirect_pc  out  32  new fetch PC

Behaviour:
- Record: {valid, pc, int, adef, ine, sys, brk, ertn, ale}. Two registers, ID->EX and EX->MEM, load when stall=0.
- EX->MEM ORs EX_ale into ale.
- If flush=1, both registers load valid=0, overriding stall.
- Interrupt tag: int=1 is set on the ID->EX load when INT=1, ID_valid=1, state=IDLE and no tagged record is in EX or MEM. At most one tagged instruction is in flight.
- MEM fault = MEM.valid and any of int, adef, ine, sys, brk, ale.
- Priority, highest first, with (Ecode, EsubCode):
  - INT (0x00, 0)
  - ADEF (0x08, 0)
  - INE (0x0D, 0)
  - SYS (0x0B, 0)
  - BRK (0x0C, 0)
  - ALE (0x09, 0)
- exc_sig = fault & state==IDLE, combinational. Ecode/EsubCode/PC are driven from the MEM record and are 0 when exc_sig=0.
- ERTN = MEM.valid & MEM.ertn & !fault & state==IDLE. Fault beats ertn.
- flush = exc_sig | ERTN.
- redirect_valid = flush. redirect_pc = EENTRY_out on a trigger, ERA_out on ERTN, else 0.
- FSM, 2 states:
  - IDLE -> FLUSH on flush=1; counter loads FLUSH_CYCLES-1.
  - FLUSH: counter decrements each cycle; -> IDLE when counter==0.
  - In FLUSH, exc_sig/ERTN/flush are 0 and interrupt tagging is blocked.
- stall=1 with a MEM fault in IDLE: trigger fires anyway; the flush clears the registers.
- Reset (async): state=IDLE, counter=0, all record valid bits 0. All outputs 0 until a valid record reaches MEM.
- Reset mid-FLUSH returns to IDLE immediately.

Optional Feature:
- Macro: EXC_ADDR_CHECK_EN.
- Defined:
  - Adds an internal check; the effective adef = ID_adef | (ID_pc[1:0]!=0).
  - ALE is also raised internally when EX_ale is qualified by an extra input EX_mem_misalign of width 1.
- Undefined: adef = ID_adef, ale = EX_ale only; no EX_mem_misalign port.

Decomposition:
- Shared package/header: Ecode/EsubCode constants (INT, ADEF, ALE, SYS, BRK, INE), state encodings, and record field widths. Reuse the existing CSR definition header entries where they exist.
- One sub-module: exc_prio_enc. Purely combinational; takes record flags and returns {fault, Ecode, EsubCode}.

Test Plan:
- SYSCALL at pc 0x1C000100, no stall, EENTRY_out=0x1C008000:
  - 2 cycles after ID: exc_sig=1, Ecode=0x0B, PC=0x1C000100, redirect_pc=0x1C008000.
  - flush=1 for exactly 1 cycle, then FLUSH for 2 cycles.
- ID_ine=1 and ID_sys=1 on the same instruction -> Ecode=0x0D only.
- INT=1 for one cycle with ID_valid=1 -> that instruction reaches MEM with Ecode=0x00. A second INT pulse while it is in flight tags nothing extra.
- ERTN with ERA_out=0x1C000204 -> ERTN=1, redirect_pc=0x1C000204, exc_sig=0.
- Fault arrives in MEM during FLUSH -> suppressed, exc_sig stays 0. With stall=1 for 3 cycles before MEM, Ecode still matches once the record advances.
- rst asserted mid-FLUSH -> all outputs 0 asynchronously, state IDLE. First post-reset fault triggers normally.
